branch_resolve_bht: RTL



---
 rtl/branch_resolve_bht_if.sv | 49 ++++
 rtl/branch_resolve_bht.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht_if.sv
// EX/IF-facing bundle of the branch resolution unit: fetch lookup, EX operands,
// the redirect handshake and the statistics counters.
interface branch_resolve_bht_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            is_branch;
  logic [2:0]      branch_type;
  logic            zero;
  logic            result0;
  logic            jal;
  logic            jalr;
  logic            ecall;
  logic            mret;
  logic            timer_interrupt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] csr_dnpc;

  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  logic [31:0]     branch_cnt;
  logic [31:0]     mispredict_cnt;

  // Pipeline side: drives fetch PC, EX operands and consumes the redirect.
  modport master (
    output if_pc, ex_valid, ex_pc, ex_pred_taken, is_branch, branch_type,
           zero, result0, jal, jalr, ecall, mret, timer_interrupt,
           target, csr_dnpc, redirect_ready,
    input  if_pred_taken, ex_ready, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt
  );

  // Resolution unit side.
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_pred_taken, is_branch, branch_type,
           zero, result0, jal, jalr, ecall, mret, timer_interrupt,
           target, csr_dnpc, redirect_ready,
    output if_pred_taken, ex_ready, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolution with a bimodal 2-bit-counter BHT: resolves control flow in EX,
// issues a registered redirect to IF, and serves IF a same-cycle prediction.
module branch_resolve_bht #(
  parameter int         XLEN        = 64,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_bht_if.slave bus
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [BHT_ENTRIES-1:0][1:0] bht_q;
  logic [IDX-1:0]              if_idx;
  logic [IDX-1:0]              ex_idx;
  logic                        unused_if_pc_bits;

  logic            acc;
  logic            cond_raw;
  logic            cond_taken;
  logic            trap_cause;
  logic            jump_cause;
  logic            train;
  logic            mispredict;
  logic            redirect_load;
  logic [XLEN-1:0] fallthrough_pc;
  logic [XLEN-1:0] redirect_pc_next;
  logic [1:0]      cnt_cur;
  logic [1:0]      cnt_next;

  logic            redirect_valid_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic [31:0]     branch_cnt_reg;
  logic [31:0]     mispredict_cnt_reg;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup: reads the registered counters, so a training write in the
  // same cycle is only visible from the next cycle on.
  // ---------------------------------------------------------------------------
  assign if_idx            = bus.if_pc[IDX+1:2];
  assign ex_idx            = bus.ex_pc[IDX+1:2];
  assign unused_if_pc_bits = ^{bus.if_pc[XLEN-1:IDX+2], bus.if_pc[1:0]};
  assign bus.if_pred_taken = bht_q[if_idx][1];

  // ---------------------------------------------------------------------------
  // EX-side decode
  // ---------------------------------------------------------------------------
  assign bus.ex_ready = !redirect_valid_reg || bus.redirect_ready;
  assign acc          = bus.ex_valid && bus.ex_ready;

  always_comb begin
    cond_raw = 1'b0;
    case (bus.branch_type)
      3'b000:          cond_raw = bus.zero;
      3'b001:          cond_raw = !bus.zero;
      3'b100, 3'b110:  cond_raw = bus.result0;
      3'b101, 3'b111:  cond_raw = !bus.result0;
      default:         cond_raw = 1'b0;
    endcase
  end

  assign cond_taken     = bus.is_branch && cond_raw;
  assign trap_cause     = bus.timer_interrupt || bus.ecall || bus.mret;
  assign jump_cause     = bus.jalr || bus.jal;
  assign mispredict     = cond_taken != bus.ex_pred_taken;
  assign train          = acc && bus.is_branch && !trap_cause && !jump_cause;
  assign fallthrough_pc = bus.ex_pc + XLEN'(4);

  // Priority: trap/mret > jalr/jal > mispredicted conditional branch.
  always_comb begin
    redirect_load    = 1'b0;
    redirect_pc_next = redirect_pc_reg;
    if (acc) begin
      if (trap_cause) begin
        redirect_load    = 1'b1;
        redirect_pc_next = bus.csr_dnpc;
      end else if (jump_cause) begin
        redirect_load    = 1'b1;
        redirect_pc_next = bus.target;
      end else if (bus.is_branch && mispredict) begin
        redirect_load    = 1'b1;
        redirect_pc_next = cond_taken ? bus.target : fallthrough_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect register: a new load wins over the consumption of the old one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else if (redirect_load) begin
      redirect_valid_reg <= 1'b1;
      redirect_pc_reg    <= redirect_pc_next;
    end else if (bus.redirect_ready) begin
      redirect_valid_reg <= 1'b0;
    end
  end

  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;

  // ---------------------------------------------------------------------------
  // BHT training: one saturating counter per entry.
  // ---------------------------------------------------------------------------
  assign cnt_cur = bht_q[ex_idx];

  always_comb begin
    cnt_next = cnt_cur;
    if (cond_taken) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= CNT_INIT;
        end else if (train && (ex_idx == IDX'(gi))) begin
          cnt_reg <= cnt_next;
        end
      end

      assign bht_q[gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Statistics: wrap silently at 32 bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (train) begin
      branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (mispredict) mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
    end
  end

  assign bus.branch_cnt     = branch_cnt_reg;
  assign bus.mispredict_cnt = mispredict_cnt_reg;
endmodule
